mc_core: RTL and testbench
==========================

Name: mc_core

Overview:
Parametrised multi-cycle successor to the single-cycle 9-bit-instruction datapath.
- Owns the PC, the instruction register, an 8-entry register file and the ALU in one block.
- Fetches instructions over a req/ack port and performs loads and stores over a second req/ack port, so both memories may have wait states.
- Generalises data width and PC width, makes the halt address a parameter, and adds start/busy control.

Parameters:
W, 8, data and register width; also the data-memory address width (W>=4).
D, 10, program counter and instruction address width.
HALT_PC, 381, PC value that halts the core when it is reached at fetch.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  pulse: begin execution from PC 0 (honoured in IDLE or HALT only).
imem_req  out  1  instruction fetch request.
imem_addr  out  D  fetch address (= PC).
imem_ack  in  1  fetch complete; imem_data valid this cycle.
imem_data  in  9  instruction word.
dmem_req  out  1  data access request.
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1.
dmem_addr  out  W  data address.
dmem_wdata  out  W  store data.
dmem_ack  in  1  access complete; dmem_rdata valid this cycle for loads.
dmem_rdata  in  W  load data.
busy  out  1  high in FETCH, EXEC and MEM.
done  out  1  high in HALT.

Behaviour:
- ISA: op=ir[8:6], rd=ir[5:3], rs=ir[2:0] (also imm3). All arithmetic is mod 2^W.
  - 000 ADD: R[rd] = R[rd] + R[rs].
  - 001 SUB: R[rd] = R[rd] - R[rs].
  - 010 AND: R[rd] = R[rd] & R[rs].
  - 011 XOR: R[rd] = R[rd] ^ R[rs].
  - 100 LSI: R[rd] = (R[rd]<<3) | imm3, high bits discarded.
  - 101 BNZ: if R[rd]!=0 then PC = PC+1+sext(imm3), else PC = PC+1.
  - 110 LD: R[rd] = mem[R[rs]].
  - 111 ST: mem[R[rs]] = R[rd].
- PC arithmetic is mod 2^D and wraps.
- States: IDLE, FETCH, EXEC, MEM, HALT.
- Reset (asynchronous, immediate):
  - state=IDLE, PC=0, IR=0, all registers=0.
  - All req/we outputs go to 0 immediately; busy=0, done=0.
  - Reset mid-transaction abandons the transaction; no write occurs.
- IDLE: start=1 -> FETCH.
- FETCH:
  - If PC==HALT_PC: imem_req=0 and next state is HALT.
  - Otherwise imem_req=1 with imem_addr=PC, held stable until the edge where imem_ack=1.
  - At that edge IR<=imem_data and next state is EXEC.
  - A same-cycle (combinational) ack is legal.
- EXEC:
  - ALU ops and LSI write R[rd] and PC<=PC+1, then go to FETCH.
  - BNZ updates PC only, then goes to FETCH.
  - LD/ST register dmem_addr=R[rs] and dmem_wdata=R[rd], then go to MEM.
- MEM:
  - dmem_req=1, and dmem_we=1 for ST; all data outputs are held stable until dmem_ack=1.
  - On the ack edge, LD writes R[rd]<=dmem_rdata; then PC<=PC+1 and next state is FETCH.
- HALT: done=1. start=1 -> PC=0, next state FETCH; register contents are retained.
- start is ignored in FETCH, EXEC and MEM.
- An ack with no request pending is ignored.
- Latency with zero-wait memories: 2 cycles per ALU/LSI/BNZ instruction, 3 cycles per LD/ST. Each wait cycle on a port adds one cycle.
- imem_addr always shows PC. dmem_addr and dmem_wdata are registered and may be stale outside MEM.
- HALT_PC==0: start goes FETCH -> HALT with no fetch issued.

Optional Feature:
Macro CYCLE_COUNT_EN.
- Defined: adds output cycle_count [31:0].
  - Cleared to 0 on reset and on each honoured start.
  - Increments every cycle that busy=1, saturating at 2^32-1.
  - Holds its value in HALT and IDLE.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Reset during MEM with dmem_req=1 -> dmem_req=0 in the same cycle as reset; state IDLE; no register changed.
- Program LSI r1,5; LSI r2,3; ADD r1,r2 with zero-wait memories -> r1=8 after 6 cycles; imem_addr sequence 0,1,2; busy high throughout.
- imem_ack delayed 3 cycles on every fetch -> imem_addr and imem_req stay stable during the wait; each instruction takes 5 cycles; results match the zero-wait run.
- LSI r3,7; ST r3,[r0]; LD r4,[r0], with memory acking after 1 wait cycle -> store seen as dmem_we=1, addr 0, wdata 7; r4=7.
- Loop LSI r1,2; SUB r1,r2 (r2=1); BNZ r1,-2, with HALT_PC=3 -> branch taken once, then PC=3; done=1; busy=0; start in HALT restarts at PC 0.
- W=16, D=4 with PC wrap: BNZ at PC 15 with offset 0 -> PC=0. ADD of 0xFFFF+1 -> 0x0000. With CYCLE_COUNT_EN defined, cycle_count equals the number of busy cycles.

Source files
------------

// File: rtl/mc_core.sv
// mc_core: multi-cycle core for the 9-bit ISA with req/ack instruction and data ports.
// Define CYCLE_COUNT_EN to add a saturating count of busy cycles on cycle_count.
module mc_core #(
    parameter int W       = 8,
    parameter int D       = 10,
    parameter int HALT_PC = 381
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         imem_req,
    output logic [D-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [8:0]   imem_data,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [W-1:0] dmem_addr,
    output logic [W-1:0] dmem_wdata,
    input  logic         dmem_ack,
    input  logic [W-1:0] dmem_rdata,
    output logic         busy,
    output logic         done
`ifdef CYCLE_COUNT_EN
    ,
    output logic [31:0]  cycle_count
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;
    typedef enum logic [2:0] {
        OP_ADD = 3'd0, OP_SUB, OP_AND, OP_XOR, OP_LSI, OP_BNZ, OP_LD, OP_ST
    } op_t;

    localparam logic [D-1:0] HALT_ADDR = D'(HALT_PC);

    state_t       state, state_n;
    logic [D-1:0] pc;
    logic [8:0]   ir;
    logic [W-1:0] regs [8];

    op_t          op;
    logic [2:0]   rd, rs;
    logic [W-1:0] alu_res;
    logic [D-1:0] pc_inc, pc_br;
    logic         at_halt;

    assign op        = op_t'(ir[8:6]);
    assign rd        = ir[5:3];
    assign rs        = ir[2:0];
    assign imem_addr = pc;
    assign at_halt   = (pc == HALT_ADDR);
    assign pc_inc    = pc + D'(1);
    // imm3 is sign-extended to the PC width; the sum wraps mod 2^D.
    assign pc_br     = (regs[rd] != '0) ? pc_inc + D'($signed(ir[2:0])) : pc_inc;

    always_comb begin
        alu_res = regs[rd];
        case (op)
            OP_ADD:  alu_res = regs[rd] + regs[rs];
            OP_SUB:  alu_res = regs[rd] - regs[rs];
            OP_AND:  alu_res = regs[rd] & regs[rs];
            OP_XOR:  alu_res = regs[rd] ^ regs[rs];
            OP_LSI:  alu_res = {regs[rd][W-4:0], ir[2:0]};
            default: alu_res = regs[rd];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // NOTE: every output and next-state gets a default before the case so no path infers a latch.
    always_comb begin
        state_n  = state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_n = S_FETCH;
            end
            S_FETCH: begin
                busy = 1'b1;
                if (at_halt) begin
                    state_n = S_HALT;
                end else begin
                    imem_req = 1'b1;
                    if (imem_ack) state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                busy    = 1'b1;
                state_n = (op == OP_LD || op == OP_ST) ? S_MEM : S_FETCH;
            end
            S_MEM: begin
                busy     = 1'b1;
                dmem_req = 1'b1;
                dmem_we  = (op == OP_ST);
                if (dmem_ack) state_n = S_FETCH;
            end
            S_HALT: begin
                done = 1'b1;
                if (start) state_n = S_FETCH;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: the register file is cleared by reset like any other state, so it lives in flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= '0;
            ir         <= '0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) pc <= '0;
                end
                S_FETCH: begin
                    if (!at_halt && imem_ack) ir <= imem_data;
                end
                S_EXEC: begin
                    case (op)
                        OP_BNZ: pc <= pc_br;
                        OP_LD, OP_ST: begin
                            dmem_addr  <= regs[rs];
                            dmem_wdata <= regs[rd];
                        end
                        default: begin
                            regs[rd] <= alu_res;
                            pc       <= pc_inc;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (op == OP_LD) regs[rd] <= dmem_rdata;
                        pc <= pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CYCLE_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (start && (state == S_IDLE || state == S_HALT)) begin
            cycle_count <= '0;
        end else if (busy && cycle_count != '1) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_core.sv
// Self-checking bench for mc_core: ISA-level model with randomized wait states, resets and programs.
// Build with CYCLE_COUNT_EN defined to also check cycle_count.
module tb_mc_core;

    localparam int W       = 8;
    localparam int D       = 5;
    localparam int HALT_PC = 6;
    localparam int NPROG   = 1 << D;
    localparam int NMEM    = 1 << W;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         imem_req;
    logic [D-1:0] imem_addr;
    logic         imem_ack = 1'b0;
    logic [8:0]   imem_data = '0;
    logic         dmem_req;
    logic         dmem_we;
    logic [W-1:0] dmem_addr;
    logic [W-1:0] dmem_wdata;
    logic         dmem_ack = 1'b0;
    logic [W-1:0] dmem_rdata = '0;
    logic         busy;
    logic         done;
`ifdef CYCLE_COUNT_EN
    logic [31:0]  cycle_count;
`endif

    always #5 clk = ~clk;

    mc_core #(.W(W), .D(D), .HALT_PC(HALT_PC)) dut (
`ifdef CYCLE_COUNT_EN
        .cycle_count(cycle_count),
`endif
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .busy(busy), .done(done)
    );

    // What the bus should be doing this cycle, from the instruction-level view.
    typedef enum {ACT_NONE, ACT_FETCH, ACT_DECODE, ACT_DATA} act_t;

    act_t         m_act;
    logic         m_run, m_halt, m_ldst, m_we;
    logic [D-1:0] m_pc, m_next_pc;
    logic [W-1:0] m_reg [8];
    logic [W-1:0] m_mem [NMEM];
    logic [W-1:0] m_addr, m_wdata;
    logic [2:0]   m_ld_rd;
    logic [31:0]  m_cc;

    logic [8:0]   prog [NPROG];
    logic [W-1:0] ram  [NMEM];

    int checks = 0, errors = 0, busy_cnt = 0;
    bit go = 0, launch = 0, req_reset = 0, rst_en = 0, spur = 0, wfix = 1;
    int imax = 0, dmax = 0, iw_left = 0, dw_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick_wait(input int mx);
        return wfix ? mx : int'($urandom_range(0, mx));
    endfunction

    task automatic model_reset();
        m_act  = ACT_NONE;
        m_run  = 1'b0;
        m_halt = 1'b0;
        m_pc   = '0;
        m_cc   = '0;
        m_ldst = 1'b0;
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
    endtask

    // Architectural effect of one instruction; memory effects wait for the data ack.
    task automatic model_decode(input logic [8:0] ir);
        logic [2:0] op, rd, rs;
        int off;
        op = ir[8:6]; rd = ir[5:3]; rs = ir[2:0];
        m_ldst    = 1'b0;
        m_next_pc = D'(int'(m_pc) + 1);
        case (op)
            3'd0: m_reg[rd] = m_reg[rd] + m_reg[rs];
            3'd1: m_reg[rd] = m_reg[rd] - m_reg[rs];
            3'd2: m_reg[rd] = m_reg[rd] & m_reg[rs];
            3'd3: m_reg[rd] = m_reg[rd] ^ m_reg[rs];
            3'd4: m_reg[rd] = W'(int'(m_reg[rd]) * 8 + int'(rs));
            3'd5: begin
                off = (rs >= 3'd4) ? int'(rs) - 8 : int'(rs);
                if (m_reg[rd] != '0) m_next_pc = D'(int'(m_pc) + 1 + off);
            end
            default: begin
                m_ldst  = 1'b1;
                m_we    = (op == 3'd7);
                m_addr  = m_reg[rs];
                m_wdata = m_reg[rd];
                m_ld_rd = rd;
            end
        endcase
    endtask

    // Asynchronous reset between edges; outputs must drop before the next clock edge.
    task automatic do_reset();
        start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_imem_req", imem_req, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_dmem_we", dmem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_imem_addr", imem_addr, 0);
`ifdef CYCLE_COUNT_EN
        check("rst_cycle_count", cycle_count, 0);
`endif
        model_reset();
        req_reset = 0;
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    // One cycle at the falling edge: compare, then drive, then advance the model past the next rise.
    task automatic step();
        bit rst_now;
        check("busy", busy, m_run);
        check("done", done, m_halt);
        check("imem_addr", imem_addr, m_pc);
        check("imem_req", imem_req, (m_act == ACT_FETCH) && (m_pc != HALT_PC));
        check("dmem_req", dmem_req, m_act == ACT_DATA);
        if (m_act == ACT_DATA) begin
            check("dmem_we", dmem_we, m_we);
            check("dmem_addr", dmem_addr, m_addr);
            check("dmem_wdata", dmem_wdata, m_wdata);
        end
`ifdef CYCLE_COUNT_EN
        check("cycle_count", cycle_count, m_cc);
`endif
        if (busy === 1'b1) busy_cnt++;

        rst_now = req_reset ||
                  (rst_en && ((dmem_req && $urandom_range(0, 19) == 0) || $urandom_range(0, 299) == 0));
        if (rst_now) begin
            do_reset();
            return;
        end

        start  = launch || (m_run && $urandom_range(0, 9) == 0);
        launch = 0;

        if (imem_req) begin
            if (iw_left == 0) begin
                imem_ack  = 1'b1;
                imem_data = prog[imem_addr];
                iw_left   = pick_wait(imax);
            end else begin
                imem_ack = 1'b0;
                iw_left--;
            end
        end else begin
            imem_ack  = spur && ($urandom_range(0, 7) == 0);
            imem_data = 9'($urandom);
        end

        if (dmem_req) begin
            if (dw_left == 0) begin
                dmem_ack   = 1'b1;
                dmem_rdata = ram[dmem_addr];
                if (dmem_we) ram[dmem_addr] = dmem_wdata;
                dw_left    = pick_wait(dmax);
            end else begin
                dmem_ack   = 1'b0;
                dmem_rdata = W'($urandom);
                dw_left--;
            end
        end else begin
            dmem_ack   = spur && ($urandom_range(0, 7) == 0);
            dmem_rdata = W'($urandom);
        end

        if (m_run && m_cc != 32'hFFFF_FFFF) m_cc = m_cc + 1;
        case (m_act)
            ACT_NONE: if (start) begin
                m_run = 1'b1; m_halt = 1'b0; m_pc = '0; m_cc = '0; m_act = ACT_FETCH;
            end
            ACT_FETCH: begin
                if (m_pc == HALT_PC) begin
                    m_run = 1'b0; m_halt = 1'b1; m_act = ACT_NONE;
                end else if (imem_ack) begin
                    model_decode(prog[m_pc]);
                    m_act = ACT_DECODE;
                end
            end
            ACT_DECODE: begin
                if (m_ldst) m_act = ACT_DATA;
                else begin
                    m_pc  = m_next_pc;
                    m_act = ACT_FETCH;
                end
            end
            ACT_DATA: if (dmem_ack) begin
                if (m_we) m_mem[m_addr] = m_wdata;
                else      m_reg[m_ld_rd] = m_mem[m_addr];
                m_pc  = m_next_pc;
                m_act = ACT_FETCH;
            end
            default: ;
        endcase
    endtask

    always @(negedge clk) if (go) step();

    task automatic run(input int budget);
        @(posedge clk);
        launch = 1;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            if (!launch && !m_run) break;
        end
    endtask

    task automatic force_reset();
        req_reset = 1;
        for (int c = 0; c < 10 && req_reset; c++) @(posedge clk);
        check("reset_serviced", req_reset, 0);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < NPROG; i++) prog[i] = 9'h000;
    endtask

    initial begin
        for (int i = 0; i < NMEM; i++) begin
            ram[i]   = W'($urandom);
            m_mem[i] = ram[i];
        end
        clear_prog();
        @(negedge clk);
        do_reset();
        go = 1;

        // Zero-wait straight-line program with a store/load round trip.
        clear_prog();
        prog[0] = 9'b100_001_101;  // LSI r1,5
        prog[1] = 9'b100_010_011;  // LSI r2,3
        prog[2] = 9'b000_001_010;  // ADD r1,r2
        prog[3] = 9'b111_001_000;  // ST  r1,[r0]
        prog[4] = 9'b110_100_000;  // LD  r4,[r0]
        prog[5] = 9'b111_100_010;  // ST  r4,[r2]
        wfix = 1; imax = 0; dmax = 0; iw_left = 0; dw_left = 0;
        busy_cnt = 0;
        run(300);
        #1;
        check("d1_done", done, 1);
        check("d1_busy_cycles", busy_cnt, 16);
        check("d1_ram0", ram[0], 8);
        check("d1_ram3", ram[3], 8);
        check("d1_model_r1", m_reg[1], 8);
        check("d1_model_r4", m_reg[4], 8);

        // Branch loop with 3 fetch wait cycles and 1 data wait cycle, from reset.
        force_reset();
        clear_prog();
        prog[0] = 9'b100_001_010;  // LSI r1,2
        prog[1] = 9'b100_010_001;  // LSI r2,1
        prog[2] = 9'b001_001_010;  // SUB r1,r2
        prog[3] = 9'b101_001_110;  // BNZ r1,-2
        prog[4] = 9'b111_010_001;  // ST  r2,[r1]
        prog[5] = 9'b110_011_001;  // LD  r3,[r1]
        imax = 3; dmax = 1; iw_left = 3; dw_left = 1;
        busy_cnt = 0;
        run(300);
        #1;
        check("d2_done", done, 1);
        check("d2_busy_cycles", busy_cnt, 45);
        check("d2_ram0", ram[0], 1);
        check("d2_model_r3", m_reg[3], 1);

        // Restart from HALT with registers retained: r2 becomes 9, loop runs 114 times.
        imax = 0; dmax = 0; iw_left = 0; dw_left = 0;
        busy_cnt = 0;
        run(1000);
        #1;
        check("d3_done", done, 1);
        check("d3_busy_cycles", busy_cnt, 467);
        check("d3_ram0", ram[0], 9);
        check("d3_model_r3", m_reg[3], 9);

        // Random programs, wait states, spurious acks, stray starts and resets.
        wfix = 0; spur = 1; rst_en = 1;
        for (int r = 0; r < 40; r++) begin
            if (r == 0 || $urandom_range(0, 2) != 0)
                for (int i = 0; i < NPROG; i++) prog[i] = 9'($urandom);
            imax = $urandom_range(0, 3);
            dmax = $urandom_range(0, 3);
            run(400);
            if (m_run) force_reset();
        end

        rst_en = 0;
        repeat (3) @(posedge clk);
        go = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
